// File: rtl/membus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : membus
// Description : Shared types and grant helper for the memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package membus;

   localparam int XLEN = 32;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   typedef enum logic [0:0] {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic              wen;
      logic [XLEN-1:0]   wdata;
      logic [XLEN/8-1:0] wmask;
   } mem_req_t;

   // D wins a tie unless fetch has been starved long enough.
   function automatic arb_owner_t arb_grant(input logic i_valid,
                                            input logic d_valid,
                                            input logic starve_hit);
      return (i_valid && (!d_valid || starve_hit)) ? OWN_I : OWN_D;
   endfunction

endpackage
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : membus_arbiter
// Description : Shares one memory port between fetch (I) and load/store (D),
//               one transaction outstanding, with a fetch starvation bound.
// Revision    : 1.0 - initial release
// ============================================================================
module membus_arbiter
   import membus::*;
#(
   parameter int ADDR_W     = XLEN,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   output logic                i_ready,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_valid,
   output logic                d_ready,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_wen,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wmask,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [ADDR_W-1:0]   m_addr,
   output logic                m_wen,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wmask,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata
);

   localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

   arb_state_t       r_state, w_state_nxt;
   arb_owner_t       r_owner, w_owner_nxt;
   logic [CNT_W-1:0] r_starve_cnt, w_starve_cnt_nxt;

   logic       w_can_issue;
   logic       w_starve_hit;
   logic       w_accept;
   arb_owner_t w_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ARB_IDLE;
         r_owner      <= OWN_I;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
      end
   end

   always_comb begin
      w_starve_hit = (STARVE_MAX != 0) && (r_starve_cnt == c_starve_max);
      // Gating with rst keeps the bus quiet while reset is held.
      w_can_issue  = !rst && ((r_state == ARB_IDLE) ||
                              ((r_state == ARB_BUSY) && m_rvalid));
      w_grant      = arb_grant(i_valid, d_valid, w_starve_hit);

      m_valid  = w_can_issue && (i_valid || d_valid);
      i_ready  = w_can_issue && i_valid && (w_grant == OWN_I) && m_ready;
      d_ready  = w_can_issue && d_valid && (w_grant == OWN_D) && m_ready;
      w_accept = m_valid && m_ready;

      m_addr  = '0;
      m_wen   = 1'b0;
      m_wdata = '0;
      m_wmask = '0;
      if (!rst) begin
         if (w_grant == OWN_I) begin
            m_addr = i_addr;
         end else begin
            m_addr  = d_addr;
            m_wen   = d_wen;
            m_wdata = d_wdata;
            m_wmask = d_wmask;
         end
      end

      i_rvalid = m_rvalid && (r_state == ARB_BUSY) && (r_owner == OWN_I);
      d_rvalid = m_rvalid && (r_state == ARB_BUSY) && (r_owner == OWN_D);
      i_rdata  = m_rdata;
      d_rdata  = m_rdata;

      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      if (w_accept) begin
         w_state_nxt = ARB_BUSY;
         w_owner_nxt = w_grant;
      end else if ((r_state == ARB_BUSY) && m_rvalid) begin
         w_state_nxt = ARB_IDLE;
      end

      w_starve_cnt_nxt = r_starve_cnt;
      if (!i_valid || i_ready) begin
         w_starve_cnt_nxt = '0;
      end else if (d_ready && (r_starve_cnt != c_starve_max)) begin
         w_starve_cnt_nxt = r_starve_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_membus_arbiter
// Description : Scoreboard bench for membus_arbiter (STARVE_MAX=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_membus_arbiter;

   localparam logic SIDE_I = 1'b0;
   localparam logic SIDE_D = 1'b1;

   typedef struct {
      logic        side;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } acc_t;

   typedef struct {
      logic        side;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_ready, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_valid, d_ready, d_wen, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wmask;
   logic        m_valid, m_ready, m_wen, m_rvalid;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wmask;

   int total = 0;
   int bad   = 0;
   acc_t acc_q[$];
   rsp_t rsp_q[$];

   membus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
      .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
      .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_acc(input logic side, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] wmask);
      acc_t e;
      e.side = side; e.addr = addr; e.wen = wen; e.wdata = wdata; e.wmask = wmask;
      acc_q.push_back(e);
   endtask

   task automatic push_rsp(input logic side, input logic [31:0] data);
      rsp_t e;
      e.side = side; e.data = data;
      rsp_q.push_back(e);
   endtask

   // Monitor: checks every bus acceptance and every routed response.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid && m_ready) begin
            if (acc_q.size() == 0) begin
               chk("acc_unexpected", {m_addr, 31'd0, m_wen}, 128'hFFFF_FFFF);
            end else begin
               acc_t e;
               e = acc_q.pop_front();
               chk("acc_addr", m_addr, e.addr);
               chk("acc_wen", m_wen, e.wen);
               chk("acc_wmask", m_wmask, e.wmask);
               if (e.wen) chk("acc_wdata", m_wdata, e.wdata);
               chk("acc_ready", {i_ready, d_ready}, {e.side == SIDE_I, e.side == SIDE_D});
            end
         end
         if (i_rvalid || d_rvalid) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", {i_rvalid, d_rvalid}, 2'b00);
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("rsp_route", {i_rvalid, d_rvalid}, {r.side == SIDE_I, r.side == SIDE_D});
               chk("rsp_data", r.side ? d_rdata : i_rdata, r.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      i_valid = 1'b1; i_addr = 32'h104;
      d_valid = 1'b1; d_addr = 32'h44; d_wen = 1'b1; d_wdata = 32'h1234; d_wmask = 4'hF;
      m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h0;

      // Outputs must stay quiet while reset is held, even with requests pending.
      @(negedge clk);
      chk("reset_quiet", {i_ready, d_ready, i_rvalid, d_rvalid, m_valid, m_wen, m_addr, m_wdata, m_wmask},
          '0);
      tick();
      i_valid = 1'b0; d_valid = 1'b0; d_wen = 1'b0; d_wdata = '0; d_wmask = '0;
      m_rvalid = 1'b0; m_ready = 1'b0;
      rst = 1'b0;
      tick();

      // Fetch only, response two cycles after acceptance.
      i_valid = 1'b1; i_addr = 32'h100; m_ready = 1'b1;
      push_acc(SIDE_I, 32'h100, 1'b0, 32'h0, 4'h0);
      tick(); i_valid = 1'b0;
      tick();
      m_rvalid = 1'b1; m_rdata = 32'h0000_0013; push_rsp(SIDE_I, 32'h13);
      tick(); m_rvalid = 1'b0;
      tick();

      // Simultaneous requests: D first, fetch issued in D's response cycle.
      i_valid = 1'b1; i_addr = 32'h200; d_valid = 1'b1; d_addr = 32'h8000;
      push_acc(SIDE_D, 32'h8000, 1'b0, 32'h0, 4'h0);
      tick(); d_valid = 1'b0;
      @(negedge clk);
      chk("busy_no_issue", {m_valid, i_ready}, 2'b00);
      tick();
      m_rvalid = 1'b1; m_rdata = 32'hAAAA_5555;
      push_rsp(SIDE_D, 32'hAAAA_5555);
      push_acc(SIDE_I, 32'h200, 1'b0, 32'h0, 4'h0);
      tick(); i_valid = 1'b0; m_rvalid = 1'b0;
      tick(); m_rvalid = 1'b1; m_rdata = 32'h1111_1111; push_rsp(SIDE_I, 32'h1111_1111);
      tick(); m_rvalid = 1'b0;
      tick();

      // Starvation: two D grants, then fetch forced; counter restarts from 0.
      i_valid = 1'b1; i_addr = 32'h300; d_valid = 1'b1; d_addr = 32'h9000;
      push_acc(SIDE_D, 32'h9000, 1'b0, 32'h0, 4'h0);
      tick(); m_rvalid = 1'b1; m_rdata = 32'hC001; d_addr = 32'h9004;
      push_rsp(SIDE_D, 32'hC001); push_acc(SIDE_D, 32'h9004, 1'b0, 32'h0, 4'h0);
      tick(); m_rdata = 32'hC002; d_addr = 32'h9008;
      push_rsp(SIDE_D, 32'hC002); push_acc(SIDE_I, 32'h300, 1'b0, 32'h0, 4'h0);
      tick(); m_rdata = 32'hC003; i_addr = 32'h304;
      push_rsp(SIDE_I, 32'hC003); push_acc(SIDE_D, 32'h9008, 1'b0, 32'h0, 4'h0);
      tick(); m_rdata = 32'hC004; d_addr = 32'h900C;
      push_rsp(SIDE_D, 32'hC004); push_acc(SIDE_D, 32'h900C, 1'b0, 32'h0, 4'h0);
      tick(); m_rdata = 32'hC005; d_addr = 32'h9010;
      push_rsp(SIDE_D, 32'hC005); push_acc(SIDE_I, 32'h304, 1'b0, 32'h0, 4'h0);
      tick(); i_valid = 1'b0; m_rdata = 32'hC006;
      push_rsp(SIDE_I, 32'hC006); push_acc(SIDE_D, 32'h9010, 1'b0, 32'h0, 4'h0);
      tick(); d_valid = 1'b0; m_rdata = 32'hC007; push_rsp(SIDE_D, 32'hC007);
      tick(); m_rvalid = 1'b0;
      tick();

      // Store held off by backpressure for three cycles.
      d_valid = 1'b1; d_addr = 32'h4000; d_wen = 1'b1; d_wdata = 32'hDEAD_BEEF;
      d_wmask = 4'b0011; m_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("store_stall", {m_valid, m_addr, m_wen, m_wdata, m_wmask, d_ready, i_ready},
             {1'b1, 32'h4000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0});
         tick();
      end
      m_ready = 1'b1;
      push_acc(SIDE_D, 32'h4000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
      tick(); d_valid = 1'b0; d_wen = 1'b0; d_wdata = '0; d_wmask = '0;
      tick(); m_rvalid = 1'b1; m_rdata = 32'h0; push_rsp(SIDE_D, 32'h0);
      tick(); m_rvalid = 1'b0;
      tick();

      // Reset while a fetch is outstanding; the late response is dropped.
      i_valid = 1'b1; i_addr = 32'h500;
      push_acc(SIDE_I, 32'h500, 1'b0, 32'h0, 4'h0);
      tick(); i_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("midbusy_reset_quiet", {m_valid, i_rvalid, d_rvalid, m_addr}, '0);
      tick(); rst = 1'b0;
      tick(); m_rvalid = 1'b1; m_rdata = 32'hBAD;
      @(negedge clk);
      chk("stale_rvalid", {i_rvalid, d_rvalid, m_valid}, 3'b000);
      tick(); m_rvalid = 1'b0;
      d_valid = 1'b1; d_addr = 32'h6000;
      push_acc(SIDE_D, 32'h6000, 1'b0, 32'h0, 4'h0);
      tick(); d_valid = 1'b0;
      tick(); m_rvalid = 1'b1; m_rdata = 32'h600D; push_rsp(SIDE_D, 32'h600D);
      tick(); m_rvalid = 1'b0;
      repeat (3) tick();

      chk("acc_q_drained", acc_q.size(), 0);
      chk("rsp_q_drained", rsp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (I side) and the load/store unit (D side).
- The D side is selected when `inst_is_memop(ctrl)` is true.
- Allows one outstanding transaction, routes each response back to its issuer, and bounds fetch starvation with a counter.
- Sits between the fetch/memory stages and the memory bus.

Parameters:
- ADDR_W, 32 (eei XLEN): address width.
- DATA_W, 32: data width. Must be a multiple of 8.
- STARVE_MAX, 4: consecutive fetch-denied cycles before fetch is forced to win. 0 disables the starvation override, giving pure D priority.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  fetch request
- i_ready  out  1  fetch request accepted this cycle
- i_addr  in  ADDR_W  fetch address
- i_rvalid  out  1  fetch response valid
- i_rdata  out  DATA_W  fetch response data
- d_valid  in  1  load/store request
- d_ready  out  1  load/store request accepted this cycle
- d_addr  in  ADDR_W  load/store address
- d_wen  in  1  1 = store, 0 = load
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  store byte enables
- d_rvalid  out  1  load data / store ack valid
- d_rdata  out  DATA_W  load data
- m_valid  out  1  memory request
- m_ready  in  1  memory accepts request
- m_addr  out  ADDR_W  memory address
- m_wen  out  1  write enable
- m_wdata  out  DATA_W  write data
- m_wmask  out  DATA_W/8  byte enables
- m_rvalid  in  1  memory response (read data or write ack), at least 1 cycle after acceptance
- m_rdata  in  DATA_W  memory read data

Behaviour:
- Clock, reset and port polarity are fixed: one clock, `clk`; `rst` is asynchronous and active-high.
- State: IDLE or BUSY, plus an owner register (OWN_I/OWN_D) and starve_cnt.
- Reset values: state=IDLE, owner=OWN_I, starve_cnt=0.
- Outputs while `rst` is held: all *_ready, *_rvalid and m_valid are 0. m_wen=0, m_addr/m_wdata/m_wmask=0.
- can_issue = (state==IDLE) || (state==BUSY && m_rvalid). Back-to-back issue is allowed in the cycle the response returns.
- Grant (combinational, evaluated only when can_issue):
  - Only one valid: grant that side.
  - Both valid: grant D, unless STARVE_MAX!=0 and starve_cnt==STARVE_MAX, in which case grant I.
- m_valid = can_issue && (i_valid || d_valid). m_* fields are muxed from the granted side. On an I grant, m_wen=0 and m_wmask=0.
- Requester valid/ready handshake:
  - x_ready = granted_x && m_ready.
  - A requester holds valid and fields stable until ready.
  - The arbiter's grant may change between cycles while m_ready=0; no lock is held before acceptance.
- On acceptance (m_valid && m_ready): state<=BUSY, owner<=granted side.
- On m_rvalid with state==BUSY and no new acceptance: state<=IDLE.
- Response routing, zero latency:
  - i_rvalid = m_rvalid && state==BUSY && owner==OWN_I.
  - d_rvalid likewise for OWN_D.
  - i_rdata = d_rdata = m_rdata, unconditionally.
- m_rvalid while IDLE (e.g. a stale response after reset mid-operation) is ignored. No x_rvalid is raised and no state change occurs.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, in each cycle where i_valid && !i_ready && d_ready.
  - Clears to 0 when i_ready=1 or i_valid=0.
  - Otherwise holds.
- Reset mid-BUSY: returns to IDLE immediately and the outstanding transaction is abandoned. Issuers are flushed by the same reset.
- The combinational path m_rvalid -> m_valid/x_ready is intentional. The memory side must not combinationally loop m_ready on m_valid.

Decomposition:
- Shared package `membus`:
  - enum ArbState {ARB_IDLE, ARB_BUSY}.
  - enum ArbOwner {OWN_I, OWN_D}.
  - struct MemReq {addr, wen, wdata, wmask}, parameterised via XLEN from eei.
  - Function `arb_grant(i_valid, d_valid, starve_hit)` returning ArbOwner.
- No sub-module; a single module with one FSM and one counter.

Test Plan:
- Fetch only: i_valid=1, i_addr=0x100, m_ready=1. Expect m_addr=0x100 and i_ready=1 in the same cycle. Memory returns m_rvalid with 0x00000013 two cycles later; expect i_rvalid=1, i_rdata=0x13, d_rvalid=0.
- Simultaneous requests: i_valid=1 (0x200) and d_valid=1 (load 0x8000) in the same cycle. Expect D granted first (m_addr=0x8000, d_ready=1, i_ready=0). Fetch is issued in the response cycle of D (m_rvalid && m_addr=0x200 && i_ready=1).
- Starvation, STARVE_MAX=2: D keeps d_valid=1 with every response at 1-cycle latency, i_valid=1 held. After 2 D grants with fetch pending, the 3rd grant goes to I; starve_cnt then reads 0.
- Store with backpressure: d_wen=1, d_wmask=4'b0011, d_wdata=0xDEADBEEF, m_ready=0 for 3 cycles. m_* stays stable and d_ready=0. When m_ready=1, expect d_ready=1; the ack raises d_rvalid, never i_rvalid.
- Reset mid-BUSY: accept a fetch, assert rst for 1 cycle, deassert. A late m_rvalid arrives: expect i_rvalid=d_rvalid=0. A new d request is then granted normally.
